// File: rtl/dut.sv
// Registered bitwise NAND stage with a configurable register chain between
// the operands and the output. Synchronous active-high reset clears the chain.
module dut #(
  parameter int unsigned BITS   = 8,
  parameter int unsigned STAGES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] out
);

  localparam int unsigned MIN_BITS   = 1;
  localparam int unsigned MAX_BITS   = 64;
  localparam int unsigned MIN_STAGES = 1;
  localparam int unsigned MAX_STAGES = 8;

  // Out-of-range widths or depths are rejected while the design is elaborated.
  if (BITS < MIN_BITS || BITS > MAX_BITS) begin : g_bad_bits
    $error("dut: BITS=%0d outside legal range 1..64", BITS);
  end
  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("dut: STAGES=%0d outside legal range 1..8", STAGES);
  end

  logic [BITS-1:0]              nand_c;
  logic [STAGES-1:0][BITS-1:0]  pipe_d;
  logic [STAGES-1:0][BITS-1:0]  pipe_q;

  always_comb begin
    nand_c = ~(a & b);
  end

  // Stage 0 captures the fresh result; later stages shift the older ones along.
  assign pipe_d[0] = nand_c;
  for (genvar s = 1; s < STAGES; s++) begin : g_shift
    assign pipe_d[s] = pipe_q[s-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign out = pipe_q[STAGES-1];

endmodule

// File: tb/tb_dut.sv
// Self-checking bench for the registered NAND unit: four instances of
// differing width/depth share one clock and reset, checked against a history model.
module tb_dut;

  localparam int unsigned HMAX = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a8, b8, o8, o83;
  logic [0:0]  a1, b1, o1;
  logic [63:0] a64, b64, o64;

  dut #(.BITS(8),  .STAGES(1)) u_s1  (.clk(clk), .reset(rst), .a(a8),  .b(b8),  .out(o8));
  dut #(.BITS(8),  .STAGES(3)) u_s3  (.clk(clk), .reset(rst), .a(a8),  .b(b8),  .out(o83));
  dut #(.BITS(1),  .STAGES(1)) u_w1  (.clk(clk), .reset(rst), .a(a1),  .b(b1),  .out(o1));
  dut #(.BITS(64), .STAGES(1)) u_w64 (.clk(clk), .reset(rst), .a(a64), .b(b64), .out(o64));

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Per-edge record of what every instance sampled, indexed by edge number.
  int          nedge = 0;
  logic [63:0] h8a [HMAX];
  logic [63:0] h8b [HMAX];
  logic [63:0] h1a [HMAX];
  logic [63:0] h1b [HMAX];
  logic [63:0] h64a[HMAX];
  logic [63:0] h64b[HMAX];
  logic        hr  [HMAX];

  always @(posedge clk) begin
    if (nedge < int'(HMAX)) begin
      h8a[nedge]  <= 64'(a8);
      h8b[nedge]  <= 64'(b8);
      h1a[nedge]  <= 64'(a1);
      h1b[nedge]  <= 64'(b1);
      h64a[nedge] <= a64;
      h64b[nedge] <= b64;
      hr[nedge]   <= rst;
    end
    nedge <= nedge + 1;
  end

  // Output after the latest edge: NAND of operands sampled STAGES-1 edges earlier,
  // or zero if any reset edge occurred from that capture edge onward.
  function automatic logic [63:0] model(input int sel, input int stages);
    int          e;
    int          src;
    logic [63:0] va, vb, m;
    e   = nedge - 1;
    src = e - (stages - 1);
    if (src < 0) return '0;
    for (int k = src; k <= e; k++) begin
      if (hr[k] !== 1'b0) return '0;
    end
    case (sel)
      1:       begin va = h1a[src];  vb = h1b[src];  m = 64'h1; end
      64:      begin va = h64a[src]; vb = h64b[src]; m = '1;    end
      default: begin va = h8a[src];  vb = h8b[src];  m = 64'hFF; end
    endcase
    return ~(va & vb) & m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic randomize_ops();
    a8  = 8'($urandom);
    b8  = 8'($urandom);
    a1  = 1'($urandom);
    b1  = 1'($urandom);
    a64 = {32'($urandom), 32'($urandom)};
    b64 = {32'($urandom), 32'($urandom)};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a8 = 8'hFF; b8 = 8'hFF;
    a1 = 1'b0;  b1 = 1'b0;
    a64 = '0;   b64 = '0;
    tick();
    tick();
    checks++;
    if (o8 !== 8'h00) begin
      errors++; $display("FAIL reset_s1 got=%h exp=00", o8);
    end
    checks++;
    if (o83 !== 8'h00) begin
      errors++; $display("FAIL reset_s3 got=%h exp=00", o83);
    end
    checks++;
    if (o1 !== 1'b0) begin
      errors++; $display("FAIL reset_w1 got=%h exp=0", o1);
    end
    checks++;
    if (o64 !== 64'h0) begin
      errors++; $display("FAIL reset_w64 got=%h exp=0", o64);
    end
    rst = 1'b0;
    a8  = 8'h00;
    tick();
    checks++;
    if (o8 !== 8'hFF) begin
      errors++; $display("FAIL release_s1 got=%h exp=ff", o8);
    end
    checks++;
    if (o83 !== 8'h00) begin
      errors++; $display("FAIL release_s3_zero got=%h exp=00", o83);
    end
  endtask

  task automatic test_directed();
    logic [7:0] va[3];
    logic [7:0] vb[3];
    logic [7:0] ve[3];
    va = '{8'hF0, 8'hAA, 8'hFF};
    vb = '{8'hCC, 8'h55, 8'h81};
    ve = '{8'h3F, 8'hFF, 8'h7E};
    for (int i = 0; i < 3; i++) begin
      a8 = va[i];
      b8 = vb[i];
      tick();
      checks++;
      if (o8 !== ve[i]) begin
        errors++; $display("FAIL directed_%0d got=%h exp=%h", i, o8, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      randomize_ops();
      tick();
      tick();
      checks++;
      if (o8 !== 8'(model(8, 1))) begin
        errors++; $display("FAIL random_s1 #%0d got=%h exp=%h", i, o8, 8'(model(8, 1)));
      end
      checks++;
      if (o1 !== 1'(model(1, 1))) begin
        errors++; $display("FAIL random_w1 #%0d got=%h exp=%h", i, o1, 1'(model(1, 1)));
      end
      checks++;
      if (o64 !== model(64, 1)) begin
        errors++; $display("FAIL random_w64 #%0d got=%h exp=%h", i, o64, model(64, 1));
      end
      tick();
      checks++;
      if (o83 !== 8'(model(8, 3))) begin
        errors++; $display("FAIL random_s3 #%0d got=%h exp=%h", i, o83, 8'(model(8, 3)));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] applied[$];
    for (int i = 0; i < 16; i++) begin
      randomize_ops();
      applied.push_back(~(a8 & b8));
      tick();
      checks++;
      if (o8 !== applied[applied.size()-1]) begin
        errors++; $display("FAIL b2b_s1 #%0d got=%h exp=%h", i, o8, applied[applied.size()-1]);
      end
      if (i >= 2) begin
        checks++;
        if (o83 !== applied[applied.size()-3]) begin
          errors++; $display("FAIL b2b_s3 #%0d got=%h exp=%h", i, o83, applied[applied.size()-3]);
        end
      end
      checks++;
      if (o83 !== 8'(model(8, 3))) begin
        errors++; $display("FAIL b2b_s3_model #%0d got=%h exp=%h", i, o83, 8'(model(8, 3)));
      end
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      tick();
    end
    rst = 1'b1;
    randomize_ops();
    tick();
    checks++;
    if (o83 !== 8'h00) begin
      errors++; $display("FAIL midrst_s3 got=%h exp=00", o83);
    end
    checks++;
    if (o8 !== 8'h00) begin
      errors++; $display("FAIL midrst_s1 got=%h exp=00", o8);
    end
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      a8 = 8'h0F ^ 8'(i);
      b8 = 8'hF3;
      tick();
      if (i < 3) begin
        checks++;
        if (o83 !== 8'h00) begin
          errors++; $display("FAIL midrst_zero_%0d got=%h exp=00", i, o83);
        end
      end
      checks++;
      if (o83 !== 8'(model(8, 3))) begin
        errors++; $display("FAIL midrst_model_%0d got=%h exp=%h", i, o83, 8'(model(8, 3)));
      end
    end
  endtask

  task automatic test_width_corners();
    logic [0:0] exp1[4];
    exp1 = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      a1 = 1'(i >> 1);
      b1 = 1'(i);
      tick();
      checks++;
      if (o1 !== exp1[i]) begin
        errors++; $display("FAIL w1_combo_%0d got=%h exp=%h", i, o1, exp1[i]);
      end
    end
    a64 = '1;
    b64 = '1;
    tick();
    checks++;
    if (o64 !== 64'h0) begin
      errors++; $display("FAIL w64_ones got=%h exp=0", o64);
    end
    a64 = '0;
    tick();
    checks++;
    if (o64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++; $display("FAIL w64_zero got=%h exp=ffffffffffffffff", o64);
    end
  endtask

  initial begin
    rst = 1'b1;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0; a64 = '0; b64 = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midstream_reset();
    test_width_corners();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
